// File: rtl/render_buffer_controller.sv
// Frame sequencer for a double-buffered renderer: starts one command pass per frame,
// holds the finished buffer until vsync, then swaps render/display buffers.
module render_buffer_controller #(
    parameter int unsigned TIMEOUT_W      = 24,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd0,
    parameter int unsigned FRAME_CNT_W    = 8,
    parameter int unsigned LATE_CNT_W     = 8
) (
    input  logic                   i_master_clk,
    input  logic                   i_reset_n,
    input  logic                   i_frame_ready,
    output logic                   o_process_start,
    input  logic                   i_process_done,
    input  logic                   i_vsync,
    output logic                   o_render_buffer,
    output logic                   o_display_buffer,
    output logic                   o_swap,
    output logic                   o_busy,
    output logic [FRAME_CNT_W-1:0] o_frame_count,
    output logic [LATE_CNT_W-1:0]  o_late_count,
    output logic                   o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RENDER,
        ST_WAIT_VSYNC,
        ST_SWAP
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    state_t               state;
    state_t               next_state;
    logic [TIMEOUT_W-1:0] wd_count;
    logic                 enter_render;
    logic                 enter_swap;
    logic                 late_vsync;
    logic                 wd_enabled;

    assign wd_enabled = (WD_LIMIT != '0);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        next_state   = state;
        enter_render = 1'b0;
        enter_swap   = 1'b0;
        late_vsync   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_frame_ready) begin
                    next_state   = ST_RENDER;
                    enter_render = 1'b1;
                end
            end
            ST_RENDER: begin
                if (i_process_done) begin
                    // A vsync coinciding with done is on time: go straight to the swap.
                    if (i_vsync) begin
                        next_state = ST_SWAP;
                        enter_swap = 1'b1;
                    end else begin
                        next_state = ST_WAIT_VSYNC;
                    end
                end else if (i_vsync) begin
                    late_vsync = 1'b1;
                end
            end
            ST_WAIT_VSYNC: begin
                if (i_vsync) begin
                    next_state = ST_SWAP;
                    enter_swap = 1'b1;
                end
            end
            ST_SWAP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the transition decision, so each pulse and the
    // buffer toggle appear in the first cycle of the state they belong to.
    always_ff @(posedge i_master_clk) begin
        // NOTE: state and outputs use non-blocking assignments so every flop samples pre-edge values.
        if (!i_reset_n) begin
            state            <= ST_IDLE;
            o_process_start  <= 1'b0;
            o_swap           <= 1'b0;
            o_busy           <= 1'b0;
            o_render_buffer  <= 1'b0;
            o_display_buffer <= 1'b1;
            o_frame_count    <= '0;
            o_late_count     <= '0;
            o_timeout        <= 1'b0;
            wd_count         <= '0;
        end else begin
            state           <= next_state;
            o_process_start <= enter_render;
            o_swap          <= enter_swap;
            o_busy          <= (next_state != ST_IDLE);

            if (enter_swap) begin
                o_render_buffer  <= ~o_render_buffer;
                o_display_buffer <= ~o_display_buffer;
                o_frame_count    <= o_frame_count + FRAME_CNT_W'(1);
            end

            if (late_vsync && (o_late_count != '1)) begin
                o_late_count <= o_late_count + LATE_CNT_W'(1);
            end

            // Watchdog only observes; the frame is never aborted and the count parks at the limit.
            if (enter_render) begin
                wd_count <= '0;
            end else if (state == ST_RENDER && wd_enabled && wd_count != WD_LIMIT) begin
                wd_count <= wd_count + TIMEOUT_W'(1);
                if (wd_count + TIMEOUT_W'(1) == WD_LIMIT) begin
                    o_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_render_buffer_controller.sv
// Directed bench for render_buffer_controller: reset, frame timing, late vsyncs,
// coincident done/vsync, watchdog and mid-render reset.
module tb_render_buffer_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_ready;
    logic       process_start;
    logic       process_done;
    logic       vsync;
    logic       render_buffer;
    logic       display_buffer;
    logic       swap;
    logic       busy;
    logic [7:0] frame_count;
    logic [7:0] late_count;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    render_buffer_controller #(
        .TIMEOUT_W      (24),
        .TIMEOUT_CYCLES (24'd100),
        .FRAME_CNT_W    (8),
        .LATE_CNT_W     (8)
    ) dut (
        .i_master_clk     (clk),
        .i_reset_n        (rst_n),
        .i_frame_ready    (frame_ready),
        .o_process_start  (process_start),
        .i_process_done   (process_done),
        .i_vsync          (vsync),
        .o_render_buffer  (render_buffer),
        .o_display_buffer (display_buffer),
        .o_swap           (swap),
        .o_busy           (busy),
        .o_frame_count    (frame_count),
        .o_late_count     (late_count),
        .o_timeout        (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        frame_ready  = 1'b0;
        process_done = 1'b0;
        vsync        = 1'b0;
        ticks(2);
        rst_n = 1'b1;
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_start"},   32'(process_start),  32'd0);
        check({tag, "_swap"},    32'(swap),           32'd0);
        check({tag, "_busy"},    32'(busy),           32'd0);
        check({tag, "_render"},  32'(render_buffer),  32'd0);
        check({tag, "_display"}, 32'(display_buffer), 32'd1);
        check({tag, "_frames"},  32'(frame_count),    32'd0);
        check({tag, "_late"},    32'(late_count),     32'd0);
        check({tag, "_timeout"}, 32'(timeout),        32'd0);
    endtask

    initial begin
        int quiet_bad;

        // Reset state, then idle with vsync pulses and no frame ready.
        do_reset();
        check_reset_values("rst");
        quiet_bad = 0;
        for (int i = 0; i < 8; i++) begin
            vsync = (i % 2 == 0);
            tick();
            quiet_bad += int'(process_start) + int'(swap) + int'(busy);
        end
        vsync = 1'b0;
        check("idle_quiet", 32'(quiet_bad), 32'd0);
        check("idle_render", 32'(render_buffer), 32'd0);
        check("idle_display", 32'(display_buffer), 32'd1);
        check("idle_late", 32'(late_count), 32'd0);

        // Frame timing: ready at cycle 0, done at 20, vsync at 50.
        frame_ready = 1'b1;
        tick();
        check("t_start_c1", 32'(process_start), 32'd1);
        check("t_busy_c1", 32'(busy), 32'd1);
        frame_ready = 1'b0;
        tick();
        check("t_start_c2", 32'(process_start), 32'd0);
        ticks(18);
        check("t_render_held", 32'(render_buffer), 32'd0);
        process_done = 1'b1;
        tick();
        process_done = 1'b0;
        check("t_busy_wait", 32'(busy), 32'd1);
        check("t_no_early_swap", 32'(swap), 32'd0);
        ticks(29);
        pulse_vsync();
        check("t_swap_c51", 32'(swap), 32'd1);
        check("t_render_c51", 32'(render_buffer), 32'd1);
        check("t_display_c51", 32'(display_buffer), 32'd0);
        check("t_frames_c51", 32'(frame_count), 32'd1);
        check("t_busy_c51", 32'(busy), 32'd1);
        tick();
        check("t_swap_c52", 32'(swap), 32'd0);
        check("t_busy_c52", 32'(busy), 32'd0);
        check("t_late_c52", 32'(late_count), 32'd0);
        check("t_timeout_c52", 32'(timeout), 32'd0);

        // Late vsyncs during render keep the old buffers.
        do_reset();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("l_start", 32'(process_start), 32'd1);
        repeat (3) begin
            tick();
            pulse_vsync();
        end
        check("l_late3", 32'(late_count), 32'd3);
        check("l_render_kept", 32'(render_buffer), 32'd0);
        check("l_display_kept", 32'(display_buffer), 32'd1);
        check("l_no_swap", 32'(swap), 32'd0);
        process_done = 1'b1;
        tick();
        process_done = 1'b0;
        tick();
        pulse_vsync();
        check("l_swap", 32'(swap), 32'd1);
        check("l_frames1", 32'(frame_count), 32'd1);
        check("l_late_after", 32'(late_count), 32'd3);
        tick();

        // Saturation of the late counter over 300 missed vsyncs.
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("s_start", 32'(process_start), 32'd1);
        repeat (300) begin
            pulse_vsync();
            tick();
        end
        check("s_late_sat", 32'(late_count), 32'd255);
        check("s_render_kept", 32'(render_buffer), 32'd1);
        check("s_frames_kept", 32'(frame_count), 32'd1);
        process_done = 1'b1;
        tick();
        process_done = 1'b0;
        pulse_vsync();
        check("s_frames2", 32'(frame_count), 32'd2);
        check("s_render_back", 32'(render_buffer), 32'd0);

        // Done and vsync in the same cycle: straight to swap, not late.
        do_reset();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        tick();
        pulse_vsync();
        check("c_late1", 32'(late_count), 32'd1);
        tick();
        process_done = 1'b1;
        vsync        = 1'b1;
        tick();
        process_done = 1'b0;
        vsync        = 1'b0;
        check("c_swap", 32'(swap), 32'd1);
        check("c_late_same", 32'(late_count), 32'd1);
        check("c_frames", 32'(frame_count), 32'd1);
        check("c_render", 32'(render_buffer), 32'd1);
        tick();
        check("c_swap_end", 32'(swap), 32'd0);
        check("c_idle", 32'(busy), 32'd0);

        // Watchdog fires after exactly 100 render cycles and stays sticky.
        do_reset();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("w_start", 32'(process_start), 32'd1);
        check("w_t0", 32'(timeout), 32'd0);
        ticks(99);
        check("w_t99", 32'(timeout), 32'd0);
        tick();
        check("w_t100", 32'(timeout), 32'd1);
        ticks(20);
        check("w_no_abort", 32'(busy), 32'd1);
        check("w_render_kept", 32'(render_buffer), 32'd0);
        process_done = 1'b1;
        tick();
        process_done = 1'b0;
        tick();
        pulse_vsync();
        check("w_swap", 32'(swap), 32'd1);
        check("w_frames", 32'(frame_count), 32'd1);
        check("w_sticky", 32'(timeout), 32'd1);
        tick();
        check("w_idle", 32'(busy), 32'd0);
        check("w_sticky_idle", 32'(timeout), 32'd1);

        // Five back-to-back frames with ready held, then reset mid-render.
        do_reset();
        check("r_timeout_clr", 32'(timeout), 32'd0);
        frame_ready = 1'b1;
        tick();
        check("r_start0", 32'(process_start), 32'd1);
        for (int f = 1; f <= 5; f++) begin
            ticks(3);
            process_done = 1'b1;
            tick();
            process_done = 1'b0;
            pulse_vsync();
            check($sformatf("r_swap%0d", f), 32'(swap), 32'd1);
            check($sformatf("r_frames%0d", f), 32'(frame_count), 32'(f));
            tick();
            check($sformatf("r_idle_gap%0d", f), 32'(process_start), 32'd0);
            tick();
            check($sformatf("r_restart%0d", f), 32'(process_start), 32'd1);
        end
        frame_ready = 1'b0;
        check("r_render_odd", 32'(render_buffer), 32'd1);
        check("r_display_odd", 32'(display_buffer), 32'd0);
        ticks(4);
        check("r_mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check_reset_values("rmid");
        rst_n = 1'b1;
        tick();
        process_done = 1'b1;
        tick();
        process_done = 1'b0;
        check("r_done_ignored", 32'(busy), 32'd0);
        check("r_no_start", 32'(process_start), 32'd0);
        pulse_vsync();
        check("r_no_swap", 32'(swap), 32'd0);
        check("r_frames_zero", 32'(frame_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
